// File: rtl/orion_types.sv
// orion_types: shared types for the orion in-order pipeline.
//   - XLEN                    datapath width
//   - wb_sel_e                writeback value select
//   - FUNCT3_LS_*             load/store width/sign encodings (RISC-V funct3)
//   - mem_state_e             memory-stage load wait FSM states
//   - ex_mem_t / mem_wb_t     EX/MEM and MEM/WB pipeline bundles
package orion_types;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    WB_SEL_ALU = 2'd0,
    WB_SEL_CMP = 2'd1,
    WB_SEL_MEM = 2'd2,
    WB_SEL_PC4 = 2'd3
  } wb_sel_e;

  localparam logic [2:0] FUNCT3_LS_B  = 3'b000;
  localparam logic [2:0] FUNCT3_LS_H  = 3'b001;
  localparam logic [2:0] FUNCT3_LS_W  = 3'b010;
  localparam logic [2:0] FUNCT3_LS_BU = 3'b100;
  localparam logic [2:0] FUNCT3_LS_HU = 3'b101;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_WAIT = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic            valid;
    logic [4:0]      rd_s;
    logic            rd_we;
    wb_sel_e         sel_wb_mux;
    logic [XLEN-1:0] alu_out;
    logic            cmp_out;
    logic [2:0]      ld_str_type;
    logic            is_load;
    logic            is_store;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] debug;
  } ex_mem_t;

  typedef struct packed {
    logic            valid;
    logic [4:0]      rd_s;
    logic            rd_we;
    logic [XLEN-1:0] rd_v;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] debug;
  } mem_wb_t;

  // Return address for jump-and-link style writeback; wraps modulo 2^XLEN.
  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// load_align: combinational load data alignment and extension.
// Ports:
//   rdata_i        [XLEN-1:0]  word-aligned read data
//   off_i          [1:0]       byte offset within the word (address bits 1:0)
//   ld_str_type_i  [2:0]       funct3 load type (B/H/W/BU/HU)
//   data_o         [XLEN-1:0]  aligned, sign/zero-extended load value
//                              (0 for any unsupported type)
module load_align
  import orion_types::*;
(
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      off_i,
  input  logic [2:0]      ld_str_type_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[7:0];
    case (off_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    // Halfword picks by off[1] only; off[0] is ignored (no misaligned support).
    half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    data_o = '0;
    case (ld_str_type_i)
      FUNCT3_LS_B:  data_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      FUNCT3_LS_BU: data_o = {{(XLEN-8){1'b0}}, byte_sel};
      FUNCT3_LS_H:  data_o = {{(XLEN-16){half_sel[15]}}, half_sel};
      FUNCT3_LS_HU: data_o = {{(XLEN-16){1'b0}}, half_sel};
      FUNCT3_LS_W:  data_o = rdata_i;
      default:      data_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory stage of the orion in-order pipeline.
// Holds the EX/MEM register, waits for the data-memory read response on
// loads, aligns/extends load data, selects the writeback value and drives a
// registered MEM/WB bundle.
// Ports:
//   clk_i           clock
//   rst_i           synchronous active-low reset
//   ex_mem_i        execute result bundle (combinational from execute)
//   dmem_rvalid_i   read response valid, one per issued load
//   dmem_rdata_i    word-aligned read data
//   stall_o         freeze request to upstream stages (combinational)
//   mem_wb_o        registered bundle to writeback
// Optional (macro ORION_MEM_PERF_EN):
//   perf_stall_cycles_o  cycles with stall_o high, wraps
//   perf_loads_o         accepted load responses, wraps
module mem_stage
  import orion_types::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  ex_mem_t         ex_mem_i,
  input  logic            dmem_rvalid_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic            stall_o,
  output mem_wb_t         mem_wb_o
`ifdef ORION_MEM_PERF_EN
  ,
  output logic [31:0]     perf_stall_cycles_o,
  output logic [31:0]     perf_loads_o
`endif
);

  ex_mem_t    mreg_q, mreg_d;
  mem_wb_t    mem_wb_q, mem_wb_d;
  mem_state_e state_q, state_d;

  logic            ld_pending;
  logic [XLEN-1:0] ld_data;
  logic [XLEN-1:0] wb_val;

  // A load sitting in mreg needs its response before it can retire.
  // stall_o reacts to rvalid in the same cycle, so a response arriving in
  // the load's first mreg cycle costs no bubble.
  assign ld_pending = mreg_q.valid & mreg_q.is_load;
  assign stall_o    = ld_pending & ~dmem_rvalid_i;

  load_align u_load_align (
    .rdata_i       (dmem_rdata_i),
    .off_i         (mreg_q.alu_out[1:0]),
    .ld_str_type_i (mreg_q.ld_str_type),
    .data_o        (ld_data)
  );

  always_comb begin
    wb_val = mreg_q.alu_out;
    case (mreg_q.sel_wb_mux)
      WB_SEL_ALU: wb_val = mreg_q.alu_out;
      WB_SEL_CMP: wb_val = {{(XLEN-1){1'b0}}, mreg_q.cmp_out};
      WB_SEL_MEM: wb_val = ld_data;
      WB_SEL_PC4: wb_val = pc_plus4(mreg_q.pc);
      default:    wb_val = mreg_q.alu_out;
    endcase
  end

  // EX/MEM register freezes with the rest of the pipe.
  always_comb begin
    mreg_d = stall_o ? mreg_q : ex_mem_i;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (ld_pending && !dmem_rvalid_i) state_d = S_WAIT;
      S_WAIT:  if (dmem_rvalid_i)                state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  always_comb begin
    mem_wb_d = mem_wb_q;
    if (stall_o) begin
      // Bubble; payload is don't-care so it is simply held.
      mem_wb_d.valid = 1'b0;
    end else begin
      mem_wb_d.valid = mreg_q.valid;
      mem_wb_d.rd_s  = mreg_q.rd_s;
      // Stores never write the register file regardless of rd_we.
      mem_wb_d.rd_we = mreg_q.rd_we & ~mreg_q.is_store;
      mem_wb_d.rd_v  = wb_val;
      mem_wb_d.pc    = mreg_q.pc;
      mem_wb_d.debug = mreg_q.debug;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      mreg_q   <= '0;
      mem_wb_q <= '0;
      state_q  <= S_RUN;
    end else begin
      mreg_q   <= mreg_d;
      mem_wb_q <= mem_wb_d;
      state_q  <= state_d;
    end
  end

  assign mem_wb_o = mem_wb_q;

`ifdef ORION_MEM_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_loads_q, perf_loads_d;

  always_comb begin
    perf_stall_d = perf_stall_q + {31'b0, stall_o};
    // Only a response to a pending load counts; stray rvalids are ignored.
    perf_loads_d = perf_loads_q + {31'b0, ld_pending & dmem_rvalid_i};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      perf_stall_q <= '0;
      perf_loads_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_loads_q <= perf_loads_d;
    end
  end

  assign perf_stall_cycles_o = perf_stall_q;
  assign perf_loads_o        = perf_loads_q;
`endif

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  import orion_types::*;

  logic        clk = 1'b0;
  logic        rst_i;
  ex_mem_t     ex_mem_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        stall_o;
  mem_wb_t     mem_wb_o;
`ifdef ORION_MEM_PERF_EN
  logic [31:0] perf_stall_cycles_o, perf_loads_o;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model state
  ex_mem_t     m_reg;
  mem_wb_t     m_wb;
  logic        m_full;
  int unsigned m_stalls, m_loads;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .ex_mem_i      (ex_mem_i),
    .dmem_rvalid_i (dmem_rvalid_i),
    .dmem_rdata_i  (dmem_rdata_i),
    .stall_o       (stall_o),
    .mem_wb_o      (mem_wb_o)
`ifdef ORION_MEM_PERF_EN
    ,
    .perf_stall_cycles_o (perf_stall_cycles_o),
    .perf_loads_o        (perf_loads_o)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Load value from byte/halfword arithmetic on the word.
  function automatic logic [31:0] ref_load(input logic [2:0] t, input logic [31:0] d,
                                           input logic [1:0] off);
    logic [31:0] b, h;
    b = (d >> (8 * off)) & 32'hFF;
    h = (d >> (16 * (off / 2))) & 32'hFFFF;
    case (t)
      3'd0:    return (b >= 128)   ? b + 32'hFFFF_FF00 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd5:    return h;
      3'd2:    return d;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_wb(input ex_mem_t e, input logic [31:0] rdata);
    case (e.sel_wb_mux)
      WB_SEL_ALU: return e.alu_out;
      WB_SEL_CMP: return e.cmp_out ? 32'd1 : 32'd0;
      WB_SEL_MEM: return ref_load(e.ld_str_type, rdata, e.alu_out[1:0]);
      default:    return e.pc + 32'd4;
    endcase
  endfunction

  function automatic ex_mem_t mk(input logic v, input logic ld, input logic st,
                                 input logic [2:0] f3, input wb_sel_e sel,
                                 input logic [31:0] alu, input logic [4:0] rd,
                                 input logic we, input logic [31:0] pc);
    ex_mem_t e;
    e = '0;
    e.valid = v; e.is_load = ld; e.is_store = st; e.ld_str_type = f3;
    e.sel_wb_mux = sel; e.alu_out = alu; e.rd_s = rd; e.rd_we = we;
    e.pc = pc; e.cmp_out = alu[0] ^ pc[2]; e.debug = pc ^ 32'hDEAD_0000;
    return e;
  endfunction

  // One clock: drive inputs, check stall mid-cycle, step model at edge,
  // then check the registered outputs.
  task automatic cyc(input ex_mem_t in, input logic rv, input logic [31:0] rd,
                     input logic rst_n);
    logic exp_stall;
    ex_mem_i = in; dmem_rvalid_i = rv; dmem_rdata_i = rd; rst_i = rst_n;
    @(negedge clk);
    exp_stall = m_reg.valid && m_reg.is_load && !rv;
    chk("stall", {31'b0, stall_o}, {31'b0, exp_stall});
    @(posedge clk);
    if (!rst_n) begin
      m_reg.valid = 1'b0; m_wb = '0; m_full = 1'b1; m_stalls = 0; m_loads = 0;
    end else if (exp_stall) begin
      m_wb.valid = 1'b0; m_full = 1'b0; m_stalls++;
    end else begin
      if (m_reg.valid && m_reg.is_load && rv) m_loads++;
      m_full     = m_reg.valid;
      m_wb.valid = m_reg.valid;
      m_wb.rd_s  = m_reg.rd_s;
      m_wb.rd_we = m_reg.rd_we && !m_reg.is_store;
      m_wb.rd_v  = ref_wb(m_reg, rd);
      m_wb.pc    = m_reg.pc;
      m_wb.debug = m_reg.debug;
      m_reg      = in;
    end
    #1;
    chk("wb_valid", {31'b0, mem_wb_o.valid}, {31'b0, m_wb.valid});
    if (m_full) begin
      chk("wb_rd_s",  {27'b0, mem_wb_o.rd_s}, {27'b0, m_wb.rd_s});
      chk("wb_rd_we", {31'b0, mem_wb_o.rd_we}, {31'b0, m_wb.rd_we});
      chk("wb_rd_v",  mem_wb_o.rd_v,  m_wb.rd_v);
      chk("wb_pc",    mem_wb_o.pc,    m_wb.pc);
      chk("wb_debug", mem_wb_o.debug, m_wb.debug);
    end
`ifdef ORION_MEM_PERF_EN
    chk("perf_stall", perf_stall_cycles_o, m_stalls);
    chk("perf_loads", perf_loads_o, m_loads);
`endif
  endtask

  ex_mem_t bub, cur;
  logic    rv, ld_pend, exp_st;
  int      dly, waited;

  initial begin
    m_reg = '0; m_wb = '0; m_full = 1'b0; m_stalls = 0; m_loads = 0;
    bub = mk(1'b0, 1'b0, 1'b0, 3'd0, WB_SEL_ALU, 32'd0, 5'd0, 1'b0, 32'd0);
    ex_mem_i = bub; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0; rst_i = 1'b0;
    @(posedge clk); #1;

    // Reset state
    cyc(bub, 1'b0, 32'd0, 1'b0);
    cyc(bub, 1'b0, 32'd0, 1'b0);
    chk("reset_wb_zero", {31'b0, (mem_wb_o == '0)}, 32'd1);

    // ALU op
    cyc(mk(1'b1, 1'b0, 1'b0, 3'd0, WB_SEL_ALU, 32'h1234, 5'd5, 1'b1, 32'h100), 1'b0, 32'd0, 1'b1);
    cyc(bub, 1'b0, 32'd0, 1'b1);
    chk("alu_rd_v", mem_wb_o.rd_v, 32'h1234);
    chk("alu_rd_s", {27'b0, mem_wb_o.rd_s}, 32'd5);

    // LB at 0x103, 3 stall cycles, then response
    cyc(mk(1'b1, 1'b1, 1'b0, FUNCT3_LS_B, WB_SEL_MEM, 32'h103, 5'd6, 1'b1, 32'h104), 1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(bub, 1'b0, $urandom, 1'b1);
    cyc(bub, 1'b1, 32'h80FF_0000, 1'b1);
    chk("lb_rd_v", mem_wb_o.rd_v, 32'hFFFF_FF80);

    // LHU at 0x102, same-cycle response
    cyc(mk(1'b1, 1'b1, 1'b0, FUNCT3_LS_HU, WB_SEL_MEM, 32'h102, 5'd7, 1'b1, 32'h108), 1'b0, 32'd0, 1'b1);
    cyc(bub, 1'b1, 32'hBEEF_1234, 1'b1);
    chk("lhu_rd_v", mem_wb_o.rd_v, 32'h0000_BEEF);

    // Store with rd_we forced, then spurious rvalids
    cyc(mk(1'b1, 1'b0, 1'b1, FUNCT3_LS_W, WB_SEL_ALU, 32'h200, 5'd9, 1'b1, 32'h10C), 1'b0, 32'd0, 1'b1);
    cyc(bub, 1'b1, 32'h5555_5555, 1'b1);
    chk("store_rd_we", {31'b0, mem_wb_o.rd_we}, 32'd0);
    cyc(bub, 1'b1, 32'h6666_6666, 1'b1);

    // Reset while a load waits; the late response must be ignored
    cyc(mk(1'b1, 1'b1, 1'b0, FUNCT3_LS_W, WB_SEL_MEM, 32'h300, 5'd3, 1'b1, 32'h110), 1'b0, 32'd0, 1'b1);
    cyc(bub, 1'b0, 32'd0, 1'b1);
    cyc(bub, 1'b0, 32'd0, 1'b0);
    cyc(bub, 1'b1, 32'h1111_2222, 1'b1);
    total++;
    assert (dut.state_q === S_RUN) else begin
      bad++;
      $error("FAIL rst_state observed=%0d expected=%0d", dut.state_q, S_RUN);
    end

    // Two loads: 2 wait cycles, then back-to-back with 0 wait cycles
    cyc(mk(1'b1, 1'b1, 1'b0, FUNCT3_LS_W, WB_SEL_MEM, 32'h400, 5'd1, 1'b1, 32'h200), 1'b0, 32'd0, 1'b1);
    cur = mk(1'b1, 1'b1, 1'b0, FUNCT3_LS_H, WB_SEL_MEM, 32'h402, 5'd2, 1'b1, 32'h204);
    cyc(cur, 1'b0, 32'd0, 1'b1);
    cyc(cur, 1'b0, 32'd0, 1'b1);
    cyc(cur, 1'b1, 32'hCAFE_F00D, 1'b1);
    cyc(bub, 1'b1, 32'h8001_0002, 1'b1);
    chk("lh_rd_v", mem_wb_o.rd_v, 32'hFFFF_8001);
    cyc(bub, 1'b0, 32'd0, 1'b1);
`ifdef ORION_MEM_PERF_EN
    chk("perf_two_stalls", perf_stall_cycles_o, 32'd2);
    chk("perf_two_loads",  perf_loads_o,       32'd2);
`endif

    // Randomized traffic
    dly = 0; waited = 0; cur = bub;
    for (int i = 0; i < 600; i++) begin
      ld_pend = m_reg.valid && m_reg.is_load;
      rv = ld_pend ? (waited >= dly) : ($urandom_range(7) == 0);
      exp_st = ld_pend && !rv;
      if (!exp_st) begin
        case ($urandom_range(3))
          0:       cur = bub;
          1:       cur = mk(1'b1, 1'b1, 1'b0, 3'($urandom_range(7)), WB_SEL_MEM,
                            $urandom, 5'($urandom), 1'($urandom), $urandom);
          2:       cur = mk(1'b1, 1'b0, 1'b1, 3'($urandom_range(2)), wb_sel_e'($urandom_range(3)),
                            $urandom, 5'($urandom), 1'($urandom), $urandom);
          default: cur = mk(1'b1, 1'b0, 1'b0, 3'($urandom_range(7)), wb_sel_e'($urandom_range(3)),
                            $urandom, 5'($urandom), 1'($urandom), $urandom);
        endcase
      end
      cyc(cur, rv, $urandom, ($urandom_range(63) != 0));
      if (exp_st) waited++;
      else begin waited = 0; dly = $urandom_range(3); end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
